// File: rtl/h264_bitstream_arbiter_pkg.sv
// Shared types and constants for the H.264 bitstream arbiter.
// Optional feature macro: H264_ARB_STATS_EN (adds the CW_COUNT statistics output).
package h264_enc_pkg;

    localparam int CW_VE_W = 25;
    localparam int CW_VL_W = 5;

    // Marker codewords injected by the arbiter itself.
    localparam logic [CW_VE_W-1:0] TRAIL_VE = 25'h0010001;
    localparam logic [CW_VE_W-1:0] DONE_VE  = 25'h0030001;
    localparam logic [CW_VL_W-1:0] MARK_VL  = 5'd1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        MB,
        TRAIL,
        FIN,
        DONE
    } arb_state_e;

    typedef enum logic {
        SRC_HDR = 1'b0,
        SRC_MB  = 1'b1
    } src_e;

    // A zero-length codeword with no marker bits carries nothing for the packer.
    function automatic logic cw_is_null(input logic [1:0]         ve_mark,
                                        input logic [CW_VL_W-1:0] vl);
        return (vl == '0) && (ve_mark == 2'b00);
    endfunction

endpackage

// File: rtl/h264_bitstream_arbiter_if.sv
// Handshake bundle between the two codeword sources, the arbiter and the byte packer.
// Optional feature macro: H264_ARB_STATS_EN (adds CW_COUNT to the bundle).
interface h264_bitstream_arbiter_if;
    import h264_enc_pkg::*;

    logic               HDR_REQ;
    logic               HDR_VALID;
    logic [CW_VE_W-1:0] HDR_VE;
    logic [CW_VL_W-1:0] HDR_VL;
    logic               HDR_LAST;
    logic               HDR_NALEND;
    logic               HDR_READY;

    logic               MB_REQ;
    logic               MB_VALID;
    logic [CW_VE_W-1:0] MB_VE;
    logic [CW_VL_W-1:0] MB_VL;
    logic               MB_LAST;
    logic               MB_NALEND;
    logic               MB_READY;

    logic               FLUSH;

    logic               OUT_VALID;
    logic [CW_VE_W-1:0] OUT_VE;
    logic [CW_VL_W-1:0] OUT_VL;
    logic               OUT_READY;

    logic [1:0]         GRANT;
    logic               BUSY;
`ifdef H264_ARB_STATS_EN
    logic [15:0]        CW_COUNT;
`endif

    // Environment side: sources, flush control and the byte packer.
    modport master (
        output HDR_REQ, HDR_VALID, HDR_VE, HDR_VL, HDR_LAST, HDR_NALEND,
        output MB_REQ, MB_VALID, MB_VE, MB_VL, MB_LAST, MB_NALEND,
        output FLUSH, OUT_READY,
        input  HDR_READY, MB_READY, OUT_VALID, OUT_VE, OUT_VL, GRANT, BUSY
`ifdef H264_ARB_STATS_EN
        , input CW_COUNT
`endif
    );

    // Arbiter side.
    modport slave (
        input  HDR_REQ, HDR_VALID, HDR_VE, HDR_VL, HDR_LAST, HDR_NALEND,
        input  MB_REQ, MB_VALID, MB_VE, MB_VL, MB_LAST, MB_NALEND,
        input  FLUSH, OUT_READY,
        output HDR_READY, MB_READY, OUT_VALID, OUT_VE, OUT_VL, GRANT, BUSY
`ifdef H264_ARB_STATS_EN
        , output CW_COUNT
`endif
    );

endinterface

// File: rtl/h264_bitstream_arbiter.sv
// Arbitrates header and macroblock codeword packets onto a single byte-packer
// port, injecting NAL trailing and end-of-stream marker codewords.
// Optional feature macro: H264_ARB_STATS_EN (CW_COUNT forwarded-codeword counter).
module h264_bitstream_arbiter
    import h264_enc_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESETN,
    h264_bitstream_arbiter_if.slave bus
);

    arb_state_e         state_q, state_d;
    src_e               src_q, src_d;
    logic               flush_q, flush_d;

    logic               sel_valid;
    logic [CW_VE_W-1:0] sel_ve;
    logic [CW_VL_W-1:0] sel_vl;
    logic               sel_last;
    logic               sel_nalend;

    logic               hdr_rdy;
    logic               mb_rdy;

    logic               vld_p0;
    logic [CW_VE_W-1:0] ve_p0;
    logic [CW_VL_W-1:0] vl_p0;

    logic               vld_p1;
    logic [CW_VE_W-1:0] ve_p1;
    logic [CW_VL_W-1:0] vl_p1;

    logic [1:0]         grant;

    // Source mux: only the owner's codeword is visible to the FSM.
    always_comb begin
        sel_valid  = 1'b0;
        sel_ve     = '0;
        sel_vl     = '0;
        sel_last   = 1'b0;
        sel_nalend = 1'b0;
        if (state_q == HDR) begin
            sel_valid  = bus.HDR_VALID;
            sel_ve     = bus.HDR_VE;
            sel_vl     = bus.HDR_VL;
            sel_last   = bus.HDR_LAST;
            sel_nalend = bus.HDR_NALEND;
        end else if (state_q == MB) begin
            sel_valid  = bus.MB_VALID;
            sel_ve     = bus.MB_VE;
            sel_vl     = bus.MB_VL;
            sel_last   = bus.MB_LAST;
            sel_nalend = bus.MB_NALEND;
        end
    end

    // Next-state, source READY and the codeword to emit this cycle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        flush_d = flush_q;
        hdr_rdy = 1'b0;
        mb_rdy  = 1'b0;
        vld_p0  = 1'b0;
        ve_p0   = '0;
        vl_p0   = '0;

        case (state_q)
            IDLE: begin
                if (bus.FLUSH || flush_q) begin
                    state_d = FIN;
                    flush_d = 1'b0;
                end else if (bus.HDR_REQ) begin
                    state_d = HDR;
                    src_d   = SRC_HDR;
                end else if (bus.MB_REQ) begin
                    state_d = MB;
                    src_d   = SRC_MB;
                end
            end
            HDR, MB: begin
                hdr_rdy = (state_q == HDR) && bus.OUT_READY;
                mb_rdy  = (state_q == MB) && bus.OUT_READY;
                if (sel_valid && bus.OUT_READY) begin
                    vld_p0 = !cw_is_null(sel_ve[17:16], sel_vl);
                    ve_p0  = sel_ve;
                    vl_p0  = sel_vl;
                    if (sel_last) begin
                        state_d = sel_nalend ? TRAIL : IDLE;
                    end
                end
            end
            TRAIL: begin
                if (bus.OUT_READY) begin
                    vld_p0  = 1'b1;
                    ve_p0   = TRAIL_VE;
                    vl_p0   = MARK_VL;
                    state_d = IDLE;
                end
            end
            FIN: begin
                if (bus.OUT_READY) begin
                    vld_p0  = 1'b1;
                    ve_p0   = DONE_VE;
                    vl_p0   = MARK_VL;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush seen while a packet or marker is in flight waits for IDLE.
        if (bus.FLUSH && (state_q != IDLE) && (state_q != DONE)) begin
            flush_d = 1'b1;
        end
    end

    // Ownership indication; TRAIL keeps the owner of the packet it closes.
    always_comb begin
        grant = 2'b00;
        case (state_q)
            HDR:     grant = 2'b01;
            MB:      grant = 2'b10;
            TRAIL:   grant = (src_q == SRC_HDR) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // p0 -> p1: state update and registered codeword output.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= IDLE;
            src_q   <= SRC_HDR;
            flush_q <= 1'b0;
            vld_p1  <= 1'b0;
            ve_p1   <= '0;
            vl_p1   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            flush_q <= flush_d;
            vld_p1  <= vld_p0;
            if (vld_p0) begin
                ve_p1 <= ve_p0;
                vl_p1 <= vl_p0;
            end
        end
    end

    assign bus.HDR_READY = hdr_rdy;
    assign bus.MB_READY  = mb_rdy;
    assign bus.OUT_VALID = vld_p1;
    assign bus.OUT_VE    = ve_p1;
    assign bus.OUT_VL    = vl_p1;
    assign bus.GRANT     = grant;
    assign bus.BUSY      = (state_q != IDLE);

`ifdef H264_ARB_STATS_EN
    logic [15:0] cw_cnt_q;

    // Count every codeword written to the packer, markers included; wraps at 16 bits.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cw_cnt_q <= '0;
        end else if (vld_p0) begin
            cw_cnt_q <= cw_cnt_q + 16'd1;
        end
    end

    assign bus.CW_COUNT = cw_cnt_q;
`endif

endmodule

// File: tb/tb_h264_bitstream_arbiter.sv
// Self-checking bench for h264_bitstream_arbiter: directed vector table,
// hand-written corner sequences and randomized packets against a stream model.
module tb_h264_bitstream_arbiter;
    import h264_enc_pkg::*;

    logic CLK = 1'b0;
    logic RESETN = 1'b0;
    always #5 CLK = ~CLK;

    h264_bitstream_arbiter_if bus();

    h264_bitstream_arbiter dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [24:0] ve;
        logic [4:0]  vl;
    } cw_t;

    // hc/mc = {REQ, VALID, LAST, NALEND}; e_rov = {HDR_READY, MB_READY, OUT_VALID}
    typedef struct {
        logic [3:0]  hc;
        logic [24:0] hve;
        logic [4:0]  hvl;
        logic [3:0]  mc;
        logic [24:0] mve;
        logic [4:0]  mvl;
        logic        ordy;
        logic [2:0]  e_rov;
        logic [24:0] e_ve;
        logic [4:0]  e_vl;
        logic [1:0]  e_gnt;
        logic        e_busy;
    } vec_t;

    localparam int NV = 14;
    localparam logic [24:0] T_VE = 25'h0010001;
    localparam logic [24:0] D_VE = 25'h0030001;

    int  n_chk = 0;
    int  n_fail = 0;
    int  exp_fwd = 0;
    cw_t obs_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.HDR_REQ = 1'b0; bus.HDR_VALID = 1'b0; bus.HDR_VE = '0; bus.HDR_VL = '0;
        bus.HDR_LAST = 1'b0; bus.HDR_NALEND = 1'b0;
        bus.MB_REQ = 1'b0; bus.MB_VALID = 1'b0; bus.MB_VE = '0; bus.MB_VL = '0;
        bus.MB_LAST = 1'b0; bus.MB_NALEND = 1'b0;
        bus.FLUSH = 1'b0; bus.OUT_READY = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (bus.OUT_VALID) obs_q.push_back('{bus.OUT_VE, bus.OUT_VL});
    endtask

    task automatic do_reset();
        idle_inputs();
        RESETN = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        obs_q.delete();
        exp_fwd = 0;
    endtask

    task automatic cmp_stream(input string name, input cw_t exp[$]);
        chk($sformatf("%s_len", name), 32'(obs_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < obs_q.size()) begin
                chk($sformatf("%s_ve%0d", name, i), 32'(obs_q[i].ve), 32'(exp[i].ve));
                chk($sformatf("%s_vl%0d", name, i), 32'(obs_q[i].vl), 32'(exp[i].vl));
            end
        end
        exp_fwd += exp.size();
        obs_q.delete();
    endtask

    task automatic chk_stats(input string name);
`ifdef H264_ARB_STATS_EN
        chk(name, 32'(bus.CW_COUNT), 32'(exp_fwd[15:0]));
`else
        n_chk = n_chk + 0;
`endif
    endtask

    task automatic run_table();
        vec_t tv[NV];
        tv = '{
            // HDR packet 1/1, 5/3, 1F/5 closing a NAL, then trailing marker
            '{4'b1000, 25'h0,     5'd0,  4'b0000, 25'h0,     5'd0,  1'b1, 3'b000, 25'h0,     5'd0,  2'b01, 1'b1},
            '{4'b1100, 25'h1,     5'd1,  4'b0000, 25'h0,     5'd0,  1'b1, 3'b101, 25'h1,     5'd1,  2'b01, 1'b1},
            '{4'b1100, 25'h5,     5'd3,  4'b0000, 25'h0,     5'd0,  1'b1, 3'b101, 25'h5,     5'd3,  2'b01, 1'b1},
            '{4'b1111, 25'h1F,    5'd5,  4'b0000, 25'h0,     5'd0,  1'b1, 3'b101, 25'h1F,    5'd5,  2'b01, 1'b1},
            '{4'b0000, 25'h0,     5'd0,  4'b0000, 25'h0,     5'd0,  1'b1, 3'b001, T_VE,      5'd1,  2'b00, 1'b0},
            // both requests together: HDR first, MB on the next IDLE cycle
            '{4'b1000, 25'h0,     5'd0,  4'b1000, 25'h0,     5'd0,  1'b1, 3'b000, 25'h0,     5'd0,  2'b01, 1'b1},
            '{4'b1110, 25'h7,     5'd3,  4'b1000, 25'h0,     5'd0,  1'b1, 3'b101, 25'h7,     5'd3,  2'b00, 1'b0},
            '{4'b0000, 25'h0,     5'd0,  4'b1000, 25'h0,     5'd0,  1'b1, 3'b000, 25'h0,     5'd0,  2'b10, 1'b1},
            '{4'b0000, 25'h0,     5'd0,  4'b1100, 25'h2,     5'd2,  1'b1, 3'b011, 25'h2,     5'd2,  2'b10, 1'b1},
            // null codeword accepted but dropped; VL=0 with marker bits still forwarded
            '{4'b0000, 25'h0,     5'd0,  4'b1100, 25'h0,     5'd0,  1'b1, 3'b010, 25'h0,     5'd0,  2'b10, 1'b1},
            '{4'b0000, 25'h0,     5'd0,  4'b1100, 25'h10000, 5'd0,  1'b1, 3'b011, 25'h10000, 5'd0,  2'b10, 1'b1},
            // REQ dropped before LAST: packet still ends on LAST, no trail without NALEND
            '{4'b0000, 25'h0,     5'd0,  4'b0110, 25'h12345, 5'd17, 1'b1, 3'b011, 25'h12345, 5'd17, 2'b00, 1'b0},
            '{4'b0000, 25'h0,     5'd0,  4'b0000, 25'h0,     5'd0,  1'b1, 3'b000, 25'h0,     5'd0,  2'b00, 1'b0},
            // packer not ready in IDLE does not block the grant
            '{4'b0000, 25'h0,     5'd0,  4'b0000, 25'h0,     5'd0,  1'b0, 3'b000, 25'h0,     5'd0,  2'b00, 1'b0}
        };
        for (int i = 0; i < NV; i++) begin
            {bus.HDR_REQ, bus.HDR_VALID, bus.HDR_LAST, bus.HDR_NALEND} = tv[i].hc;
            bus.HDR_VE = tv[i].hve; bus.HDR_VL = tv[i].hvl;
            {bus.MB_REQ, bus.MB_VALID, bus.MB_LAST, bus.MB_NALEND} = tv[i].mc;
            bus.MB_VE = tv[i].mve; bus.MB_VL = tv[i].mvl;
            bus.OUT_READY = tv[i].ordy;
            #1;
            chk($sformatf("tv%0d_hdr_ready", i), 32'(bus.HDR_READY), 32'(tv[i].e_rov[2]));
            chk($sformatf("tv%0d_mb_ready", i), 32'(bus.MB_READY), 32'(tv[i].e_rov[1]));
            @(posedge CLK);
            #1;
            chk($sformatf("tv%0d_out_valid", i), 32'(bus.OUT_VALID), 32'(tv[i].e_rov[0]));
            if (tv[i].e_rov[0]) begin
                chk($sformatf("tv%0d_out_ve", i), 32'(bus.OUT_VE), 32'(tv[i].e_ve));
                chk($sformatf("tv%0d_out_vl", i), 32'(bus.OUT_VL), 32'(tv[i].e_vl));
                exp_fwd++;
            end
            chk($sformatf("tv%0d_grant", i), 32'(bus.GRANT), 32'(tv[i].e_gnt));
            chk($sformatf("tv%0d_busy", i), 32'(bus.BUSY), 32'(tv[i].e_busy));
        end
        idle_inputs();
        chk_stats("tv_cw_count");
    endtask

    task automatic seq_backpressure();
        cw_t pk[4];
        cw_t exp[$];
        int  k = 0;
        int  cyc = 0;
        logic xfer;
        pk[0] = '{25'h0ABCDE, 5'd20};
        pk[1] = '{25'h0000003, 5'd2};
        pk[2] = '{25'h1FFFFFF, 5'd24};
        pk[3] = '{25'h0000055, 5'd7};
        bus.MB_REQ = 1'b1;
        tick();
        while (k < 4 && cyc < 40) begin
            bus.MB_VALID = 1'b1;
            bus.MB_VE = pk[k].ve; bus.MB_VL = pk[k].vl;
            bus.MB_LAST = (k == 3); bus.MB_NALEND = (k == 3);
            bus.OUT_READY = !(cyc >= 2 && cyc < 7);
            #1;
            xfer = bus.MB_VALID && bus.MB_READY;
            if (!bus.OUT_READY) chk($sformatf("bp_mb_ready_c%0d", cyc), 32'(bus.MB_READY), 32'd0);
            tick();
            if (!bus.OUT_READY) chk($sformatf("bp_out_valid_c%0d", cyc), 32'(bus.OUT_VALID), 32'd0);
            if (xfer) k++;
            cyc++;
        end
        chk("bp_transfers", 32'(k), 32'd4);
        idle_inputs();
        for (int w = 0; w < 6; w++) tick();
        chk("bp_idle", 32'(bus.BUSY), 32'd0);
        for (int i = 0; i < 4; i++) exp.push_back(pk[i]);
        exp.push_back('{T_VE, 5'd1});
        cmp_stream("bp", exp);
        chk_stats("bp_cw_count");
    endtask

    function automatic cw_t rnd_cw();
        cw_t c;
        if ($urandom_range(0, 4) == 0) begin
            c.ve = '0;
            c.vl = '0;
        end else begin
            c.ve = 25'($urandom);
            c.vl = 5'($urandom_range(0, 24));
        end
        return c;
    endfunction

    task automatic run_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            cw_t hp[$];
            cw_t mp[$];
            cw_t exp[$];
            int  sel, hi, mi, cyc;
            logic hn, mn, hv, mv, hx, mx;
            sel = $urandom_range(1, 3);
            hn = 1'($urandom_range(0, 1));
            mn = 1'($urandom_range(0, 1));
            if (sel[0]) for (int i = $urandom_range(1, 4); i > 0; i--) hp.push_back(rnd_cw());
            if (sel[1]) for (int i = $urandom_range(1, 4); i > 0; i--) mp.push_back(rnd_cw());
            // Model: HDR packet wins, then MB; null codewords vanish; NAL close adds a trail.
            foreach (hp[i]) if (!(hp[i].vl == 0 && hp[i].ve[17:16] == 2'b00)) exp.push_back(hp[i]);
            if (hp.size() > 0 && hn) exp.push_back('{T_VE, 5'd1});
            foreach (mp[i]) if (!(mp[i].vl == 0 && mp[i].ve[17:16] == 2'b00)) exp.push_back(mp[i]);
            if (mp.size() > 0 && mn) exp.push_back('{T_VE, 5'd1});

            hi = 0; mi = 0; cyc = 0;
            bus.HDR_REQ = (hp.size() > 0);
            bus.MB_REQ = (mp.size() > 0);
            while ((hi < hp.size() || mi < mp.size() || bus.BUSY) && cyc < 400) begin
                hv = (hi < hp.size()) && ($urandom_range(0, 3) != 0);
                mv = (mi < mp.size()) && ($urandom_range(0, 3) != 0);
                bus.HDR_VALID = hv;
                bus.HDR_VE = hv ? hp[hi].ve : 25'h0;
                bus.HDR_VL = hv ? hp[hi].vl : 5'h0;
                bus.HDR_LAST = hv && (hi == hp.size() - 1);
                bus.HDR_NALEND = hv && (hi == hp.size() - 1) && hn;
                bus.MB_VALID = mv;
                bus.MB_VE = mv ? mp[mi].ve : 25'h0;
                bus.MB_VL = mv ? mp[mi].vl : 5'h0;
                bus.MB_LAST = mv && (mi == mp.size() - 1);
                bus.MB_NALEND = mv && (mi == mp.size() - 1) && mn;
                bus.OUT_READY = ($urandom_range(0, 3) != 0);
                #1;
                hx = bus.HDR_VALID && bus.HDR_READY;
                mx = bus.MB_VALID && bus.MB_READY;
                if (hx) chk($sformatf("rnd%0d_hdr_grant", r), 32'(bus.GRANT), 32'd1);
                if (mx) chk($sformatf("rnd%0d_mb_grant", r), 32'(bus.GRANT), 32'd2);
                if (mx && hi < hp.size()) chk($sformatf("rnd%0d_hdr_first", r), 32'(hi), 32'(hp.size()));
                tick();
                if (hx) begin
                    hi++;
                    if (hi == hp.size()) bus.HDR_REQ = 1'b0;
                end
                if (mx) begin
                    mi++;
                    if (mi == mp.size()) bus.MB_REQ = 1'b0;
                end
                cyc++;
            end
            chk($sformatf("rnd%0d_timeout", r), 32'(cyc < 400), 32'd1);
            idle_inputs();
            cmp_stream($sformatf("rnd%0d", r), exp);
        end
        chk_stats("rnd_cw_count");
    endtask

    task automatic seq_flush();
        cw_t exp[$];
        bus.MB_REQ = 1'b1;
        tick();
        bus.MB_VALID = 1'b1; bus.MB_VE = 25'h33; bus.MB_VL = 5'd6;
        bus.FLUSH = 1'b1;
        bus.HDR_REQ = 1'b1; bus.HDR_VALID = 1'b1; bus.HDR_VE = 25'h9; bus.HDR_VL = 5'd4;
        bus.HDR_LAST = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        bus.MB_VE = 25'h44; bus.MB_VL = 5'd7; bus.MB_LAST = 1'b1; bus.MB_NALEND = 1'b1;
        tick();
        bus.MB_LAST = 1'b0; bus.MB_NALEND = 1'b0;
        for (int w = 0; w < 8; w++) tick();
        #1;
        chk("fl_busy", 32'(bus.BUSY), 32'd1);
        chk("fl_grant", 32'(bus.GRANT), 32'd0);
        chk("fl_hdr_ready", 32'(bus.HDR_READY), 32'd0);
        chk("fl_mb_ready", 32'(bus.MB_READY), 32'd0);
        chk("fl_out_valid", 32'(bus.OUT_VALID), 32'd0);
        exp.push_back('{25'h33, 5'd6});
        exp.push_back('{25'h44, 5'd7});
        exp.push_back('{T_VE, 5'd1});
        exp.push_back('{D_VE, 5'd1});
        cmp_stream("fl", exp);
        chk_stats("fl_cw_count");
        idle_inputs();
    endtask

    task automatic seq_reset();
        cw_t exp[$];
        do_reset();
        bus.HDR_REQ = 1'b1;
        tick();
        bus.HDR_VALID = 1'b1; bus.HDR_VE = 25'hAA; bus.HDR_VL = 5'd8;
        tick();
        bus.HDR_VE = 25'hBB; bus.HDR_VL = 5'd9; bus.HDR_LAST = 1'b1; bus.HDR_NALEND = 1'b1;
        RESETN = 1'b0;
        tick();
        chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_out_ve", 32'(bus.OUT_VE), 32'd0);
        chk("rst_out_vl", 32'(bus.OUT_VL), 32'd0);
        chk("rst_grant", 32'(bus.GRANT), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        RESETN = 1'b1;
        idle_inputs();
        obs_q.delete();
        exp_fwd = 0;
        for (int w = 0; w < 4; w++) tick();
        chk("rst_no_trail", 32'(obs_q.size()), 32'd0);
        bus.HDR_REQ = 1'b1;
        tick();
        chk("rst_regrant", 32'(bus.GRANT), 32'd1);
        bus.HDR_VALID = 1'b1; bus.HDR_VE = 25'h5A; bus.HDR_VL = 5'd7; bus.HDR_LAST = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk("rst_idle", 32'(bus.BUSY), 32'd0);
        exp.push_back('{25'h5A, 5'd7});
        cmp_stream("rst", exp);
        chk_stats("rst_cw_count");
    endtask

    initial begin
        do_reset();
        chk("reset_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("reset_out_ve", 32'(bus.OUT_VE), 32'd0);
        chk("reset_out_vl", 32'(bus.OUT_VL), 32'd0);
        chk("reset_grant", 32'(bus.GRANT), 32'd0);
        chk("reset_busy", 32'(bus.BUSY), 32'd0);
        chk_stats("reset_cw_count");
        run_table();
        seq_backpressure();
        run_random(30);
        seq_flush();
        seq_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
        $fatal(1);
    end

endmodule
